// File: rtl/fetch_unit.sv
// Instruction fetch front end. It owns the PC and keeps at most one
// instruction-memory request outstanding. Fetched instructions go to decode
// through a one-entry output buffer. A jump from execute redirects the PC,
// kills any in-flight fetch and flushes the younger pipeline stages.
//
// Handshakes:
//   imem: a request is accepted in a cycle where imem_req_o && imem_gnt_i.
//         A grant while imem_req_o=0 is ignored. Exactly one imem_rvalid_i
//         follows each accepted request, in order. An rvalid that arrives
//         outside RESP (for example a stray response after reset) is ignored.
//   decode: an instruction transfers in a cycle where inst_valid_o &&
//         inst_ready_i. inst_o/inst_addr_o hold stable while inst_valid_o=1
//         and inst_ready_i=0, unless a jump flushes the buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic        flush_o,
   output logic [31:0] pc_o,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_REQ   = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic        kill_q;
   logic        buf_valid_q;
   logic [31:0] buf_inst_q;
   logic [31:0] buf_addr_q;

   logic        req_fire;
   logic        resp_fire;
   logic        capture;
   logic        drain;
   logic [31:0] jump_target;
   logic        unused_jump_lsb;

   // Jump targets are forced to word alignment; the low two bits carry no meaning here.
   assign jump_target     = {jump_addr_i[31:2], 2'b00};
   assign unused_jump_lsb = ^jump_addr_i[1:0];

   // State register; reset lands in START so no request is issued on the release cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_START;
      else      state_q <= state_d;
   end

   // Next-state logic. A grant that coincides with a jump still moves to RESP,
   // because that response will arrive and must be absorbed (kill is set).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START: state_d = ST_REQ;
         ST_REQ:   if (req_fire) state_d = ST_RESP;
         ST_RESP:  if (imem_rvalid_i) state_d = ST_REQ;
         default:  state_d = ST_START;
      endcase
   end

   // Output and handshake decode. A new request needs room in the output buffer:
   // either it is empty or decode drains it this cycle.
   always_comb begin
      drain       = buf_valid_q && inst_ready_i;
      imem_req_o  = (state_q == ST_REQ) && !hold_flag_i && (!buf_valid_q || inst_ready_i);
      req_fire    = imem_req_o && imem_gnt_i;
      resp_fire   = (state_q == ST_RESP) && imem_rvalid_i;
      capture     = resp_fire && !kill_q && !jump_en_i;
      imem_addr_o = pc_q;
      pc_o        = pc_q;
      flush_o     = jump_en_i;
      inst_valid_o = buf_valid_q;
      inst_o      = buf_valid_q ? buf_inst_q : NOP_INST;
      inst_addr_o = buf_addr_q;
      dbg_state   = state_q;
   end

   // PC: a jump wins over the post-grant increment; the increment wraps modulo 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           pc_q <= RESET_ADDR;
      else if (jump_en_i) pc_q <= jump_target;
      else if (req_fire)  pc_q <= pc_q + 32'd4;
   end

   // Remember the address of the outstanding request so the response can be tagged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          addr_q <= RESET_ADDR;
      else if (req_fire) addr_q <= pc_q;
   end

   // Kill marks the outstanding response as stale. It is cleared when that response
   // arrives; a jump with no response this cycle (in RESP, or on a grant) sets it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         kill_q <= 1'b0;
      else if (resp_fire)
         kill_q <= 1'b0;
      else if (jump_en_i && ((state_q == ST_RESP) || req_fire))
         kill_q <= 1'b1;
   end

   // Output buffer: a jump flushes it, a fresh capture beats a same-cycle drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid_q <= 1'b0;
         buf_inst_q  <= NOP_INST;
         buf_addr_q  <= 32'h0;
      end else if (jump_en_i) begin
         buf_valid_q <= 1'b0;
      end else if (capture) begin
         buf_valid_q <= 1'b1;
         buf_inst_q  <= imem_rdata_i;
         buf_addr_q  <= addr_q;
      end else if (drain) begin
         buf_valid_q <= 1'b0;
      end
   end

endmodule
